// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex readout of a 16-bit word on a 4-digit common-anode display.
// A pending/shadow double buffer means a digit can only change at a frame boundary.
module hex_display_scanner #(
  parameter  int REFRESH_DIV = 100000,
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             active_q, active_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_blz_q, pend_blz_d;
  logic [15:0]      shd_val_q, shd_val_d;
  logic [3:0]       shd_dp_q, shd_dp_d;
  logic             shd_blz_q, shd_blz_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpn_q, dpn_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic             blanked;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign boundary   = tick && (idx_q == 2'd3);
  assign frame_done = boundary;

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    active_d = active_q | tick;
  end

  // A strobe on the boundary cycle skips pending and lands in shadow directly.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_blz_d = pend_blz_q;
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    shd_blz_d  = shd_blz_q;
    if (value_valid) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pend_blz_d = blank_lz;
    end
    if (boundary) begin
      shd_val_d = pend_val_d;
      shd_dp_d  = pend_dp_d;
      shd_blz_d = pend_blz_d;
    end
  end

  always_comb begin
    nibble  = 4'h0;
    blanked = 1'b0;
    case (idx_d)
      2'd0: nibble = shd_val_d[3:0];
      2'd1: nibble = shd_val_d[7:4];
      2'd2: nibble = shd_val_d[11:8];
      default: nibble = shd_val_d[15:12];
    endcase
    // Digit 0 always shows, so a zero value still reads "0".
    case (idx_d)
      2'd1: blanked = shd_blz_d && (shd_val_d[15:4] == 12'h000);
      2'd2: blanked = shd_blz_d && (shd_val_d[15:8] == 8'h00);
      2'd3: blanked = shd_blz_d && (shd_val_d[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (active_d && !blanked) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = hex_to_seg(nibble);
      dpn_d = ~shd_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= 2'd3;
      active_q   <= 1'b0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_blz_q <= 1'b0;
      shd_val_q  <= 16'h0000;
      shd_dp_q   <= 4'h0;
      shd_blz_q  <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dpn_q      <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_blz_q <= pend_blz_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      shd_blz_q  <= shd_blz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dpn_q      <= dpn_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dpn_q;

endmodule
